// File: rtl/ddr_uart_readback.sv
// Reads one 256-bit beat from the DDR controller's AXI read port and streams its 32 bytes
// out over an 8N1 UART, byte 0 (RDATA[7:0]) first, each byte LSB first.
module ddr_uart_readback #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter logic [7:0]  AXI_ID       = 8'h01
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_trig,
  input  logic [31:0]  i_addr,
  output logic [7:0]   DdrCtrl_AID_0,
  output logic [31:0]  DdrCtrl_AADDR_0,
  output logic [7:0]   DdrCtrl_ALEN_0,
  output logic [2:0]   DdrCtrl_ASIZE_0,
  output logic [1:0]   DdrCtrl_ABURST_0,
  output logic [1:0]   DdrCtrl_ALOCK_0,
  output logic         DdrCtrl_AVALID_0,
  input  logic         DdrCtrl_AREADY_0,
  output logic         DdrCtrl_ATYPE_0,
  input  logic [255:0] DdrCtrl_RDATA_0,
  input  logic         DdrCtrl_RVALID_0,
  input  logic         DdrCtrl_RLAST_0,
  input  logic [1:0]   DdrCtrl_RRESP_0,
  output logic         DdrCtrl_RREADY_0,
  output logic         o_tx,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err
);

  localparam int unsigned DATA_W   = 256;
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, AREQ, RWAIT, TX_START, TX_DATA, TX_STOP, DONE
  } stateType;

  stateType          state, nextState;
  logic [31:0]       addrReg;
  logic [DATA_W-1:0] shiftBuf;
  logic              errFlag;
  logic [15:0]       clkCnt;
  logic [2:0]        bitIdx;
  logic [4:0]        byteIdx;
  logic              bitEnd;
  logic              unusedRlast;

  // A single beat is requested, so the last-beat marker carries no information.
  assign unusedRlast = DdrCtrl_RLAST_0;
  assign bitEnd      = (clkCnt == BIT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState        = state;
    DdrCtrl_AVALID_0 = 1'b0;
    DdrCtrl_RREADY_0 = 1'b0;
    o_tx             = 1'b1;
    o_busy           = (state != IDLE);
    o_done           = 1'b0;
    o_err            = 1'b0;
    case (state)
      IDLE:     if (i_trig) nextState = AREQ;
      AREQ: begin
        DdrCtrl_AVALID_0 = 1'b1;
        if (DdrCtrl_AREADY_0) nextState = RWAIT;
      end
      RWAIT: begin
        DdrCtrl_RREADY_0 = 1'b1;
        if (DdrCtrl_RVALID_0) nextState = (DdrCtrl_RRESP_0 == 2'b00) ? TX_START : DONE;
      end
      TX_START: begin
        o_tx = 1'b0;
        if (bitEnd) nextState = TX_DATA;
      end
      TX_DATA: begin
        o_tx = shiftBuf[0];
        if (bitEnd && bitIdx == 3'd7) nextState = TX_STOP;
      end
      TX_STOP:  if (bitEnd) nextState = (byteIdx == 5'd31) ? DONE : TX_START;
      DONE: begin
        o_done    = 1'b1;
        o_err     = errFlag;
        nextState = IDLE;
      end
      default:  nextState = IDLE;
    endcase
  end

  // Address fields are constant or register-held, so they stay stable while AVALID waits.
  assign DdrCtrl_AID_0    = AXI_ID;
  assign DdrCtrl_AADDR_0  = addrReg;
  assign DdrCtrl_ALEN_0   = 8'd0;
  assign DdrCtrl_ASIZE_0  = 3'd5;
  assign DdrCtrl_ABURST_0 = 2'b01;
  assign DdrCtrl_ALOCK_0  = 2'b00;
  assign DdrCtrl_ATYPE_0  = 1'b0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addrReg  <= '0;
      shiftBuf <= '0;
      errFlag  <= 1'b0;
      clkCnt   <= '0;
      bitIdx   <= '0;
      byteIdx  <= '0;
    end else begin
      case (state)
        IDLE: if (i_trig) begin
          addrReg <= i_addr;
          byteIdx <= '0;
        end
        RWAIT: if (DdrCtrl_RVALID_0) begin
          shiftBuf <= DdrCtrl_RDATA_0;
          errFlag  <= |DdrCtrl_RRESP_0;
          clkCnt   <= '0;
        end
        TX_START: begin
          bitIdx <= '0;
          clkCnt <= bitEnd ? '0 : clkCnt + 16'd1;
        end
        // Shifting one bit per data slot leaves the next byte in [7:0] after every 8 bits.
        TX_DATA: begin
          if (bitEnd) begin
            clkCnt   <= '0;
            bitIdx   <= bitIdx + 3'd1;
            shiftBuf <= shiftBuf >> 1;
          end else begin
            clkCnt <= clkCnt + 16'd1;
          end
        end
        TX_STOP: begin
          if (bitEnd) begin
            clkCnt <= '0;
            if (byteIdx != 5'd31) byteIdx <= byteIdx + 5'd1;
          end else begin
            clkCnt <= clkCnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_uart_readback.sv
// Bench for ddr_uart_readback: AXI slave driven from tasks, UART decoded by a monitor that
// pops expected bytes from a scoreboard queue filled when read data is presented.
module tb_ddr_uart_readback;

  localparam int         CPB   = 4;
  localparam logic [7:0] TB_ID = 8'h5A;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         trig;
  logic [31:0]  addr;
  logic [7:0]   aid;
  logic [31:0]  aaddr;
  logic [7:0]   alen;
  logic [2:0]   asize;
  logic [1:0]   aburst;
  logic [1:0]   alock;
  logic         avalid;
  logic         aready;
  logic         atype;
  logic [255:0] rdata;
  logic         rvalid;
  logic         rlast;
  logic [1:0]   rresp;
  logic         rready;
  logic         tx;
  logic         busy;
  logic         done;
  logic         err;

  int checks = 0;
  int errors = 0;
  logic [7:0] expQ[$];

  int doneCnt = 0;
  int avCnt = 0;
  int txLowCnt = 0;

  int monState = 0;
  int monCnt = 0;
  logic [7:0] monByte;

  always #5 clk = ~clk;

  ddr_uart_readback #(.CLKS_PER_BIT(CPB), .AXI_ID(TB_ID)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_trig(trig), .i_addr(addr),
    .DdrCtrl_AID_0(aid), .DdrCtrl_AADDR_0(aaddr), .DdrCtrl_ALEN_0(alen),
    .DdrCtrl_ASIZE_0(asize), .DdrCtrl_ABURST_0(aburst), .DdrCtrl_ALOCK_0(alock),
    .DdrCtrl_AVALID_0(avalid), .DdrCtrl_AREADY_0(aready), .DdrCtrl_ATYPE_0(atype),
    .DdrCtrl_RDATA_0(rdata), .DdrCtrl_RVALID_0(rvalid), .DdrCtrl_RLAST_0(rlast),
    .DdrCtrl_RRESP_0(rresp), .DdrCtrl_RREADY_0(rready),
    .o_tx(tx), .o_busy(busy), .o_done(done), .o_err(err)
  );

  always @(negedge clk) begin
    if (done === 1'b1)   doneCnt++;
    if (avalid === 1'b1) avCnt++;
    if (tx === 1'b0)     txLowCnt++;
  end

  // UART decoder: mid-bit sampling on the falling clock edge
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      monState = 0;
      monCnt = 0;
    end else if (monState == 0) begin
      if (tx === 1'b0) begin
        monState = 1;
        monCnt = 0;
      end
    end else begin
      monCnt++;
      if (monCnt == CPB/2) begin
        checks++;
        if (tx !== 1'b0) begin
          errors++;
          $display("FAIL start_bit: got %b want 0", tx);
        end
      end else if (monCnt < 9*CPB && monCnt > CPB && (monCnt - CPB/2) % CPB == 0) begin
        monByte[monCnt/CPB - 1] = tx;
      end else if (monCnt == 9*CPB + CPB/2) begin
        checks++;
        if (tx !== 1'b1) begin
          errors++;
          $display("FAIL stop_bit: got %b want 1", tx);
        end
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL uart_byte: got %02h want none (unexpected byte)", monByte);
        end else begin
          logic [7:0] e;
          e = expQ.pop_front();
          if (monByte !== e) begin
            errors++;
            $display("FAIL uart_byte: got %02h want %02h", monByte, e);
          end
        end
        monState = 0;
      end
    end
  end

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic issue(input logic [31:0] a);
    @(posedge clk); #1;
    trig = 1'b1;
    addr = a;
    @(posedge clk); #1;
    trig = 1'b0;
    addr = $urandom;
  endtask

  task automatic serve_ar(input int dly, output int vcyc, output logic [56:0] fld,
                          output bit stable, output bit ok);
    logic [56:0] cur;
    vcyc = 0; stable = 1'b1; ok = 1'b0; fld = '0;
    for (int g = 0; g < 200 && !ok; g++) begin
      @(negedge clk);
      if (avalid === 1'b1) begin
        cur = {aid, aaddr, alen, asize, aburst, alock, atype, rready};
        if (vcyc == 0) fld = cur;
        else if (cur !== fld) stable = 1'b0;
        vcyc++;
        if (vcyc > dly) begin
          aready = 1'b1;
          @(posedge clk); #1;
          aready = 1'b0;
          ok = 1'b1;
        end
      end
    end
  endtask

  task automatic serve_r(input int dly, input logic [255:0] d, input logic [1:0] resp,
                         output bit waitOk, output bit ok);
    waitOk = 1'b1; ok = 1'b0;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (rready !== 1'b1 || tx !== 1'b1) waitOk = 1'b0;
    end
    @(negedge clk);
    rdata = d; rresp = resp; rlast = 1'($urandom); rvalid = 1'b1;
    if (resp == 2'b00) for (int b = 0; b < 32; b++) expQ.push_back(d[8*b +: 8]);
    for (int g = 0; g < 100 && !ok; g++) begin
      if (rready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    rvalid = 1'b0; rdata = rand256(); rresp = 2'($urandom); rlast = 1'b0;
  endtask

  task automatic wait_fall(output int n, output bit ok);
    n = 0; ok = 1'b0;
    for (int g = 0; g < 200 && !ok; g++) begin
      @(negedge clk);
      n++;
      if (tx === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic wait_done(input int maxc, output int n, output logic errAt, output bit ok);
    n = 0; ok = 1'b0; errAt = 1'bx;
    for (int g = 0; g < maxc && !ok; g++) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) begin
        ok = 1'b1;
        errAt = err;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; trig = 1'b0; addr = '0; aready = 1'b0;
    rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1)     begin errors++; $display("FAIL rst_tx: got %b want 1", tx); end
    checks++; if (avalid !== 1'b0) begin errors++; $display("FAIL rst_avalid: got %b want 0", avalid); end
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL rst_rready: got %b want 0", rready); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (err !== 1'b0)    begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++; $display("FAIL idle_after_rst: got busy=%b tx=%b want busy=0 tx=1", busy, tx);
    end
  endtask

  task automatic test_readback();
    int vcyc, n, d0;
    logic [56:0] fld;
    logic [255:0] d;
    logic errAt;
    bit stable, ok, wok;
    for (int i = 0; i < 32; i++) d[8*i +: 8] = 8'(i);
    @(posedge clk); d0 = doneCnt;
    issue(32'h100);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_areq: got %b want 1", busy); end
    serve_ar(3, vcyc, fld, stable, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ar_handshake: got timeout want handshake"); end
    checks++; if (vcyc != 4) begin errors++; $display("FAIL avalid_cycles: got %0d want 4", vcyc); end
    checks++;
    if (fld !== {TB_ID, 32'h100, 8'h00, 3'd5, 2'b01, 2'b00, 1'b0, 1'b0}) begin
      errors++; $display("FAIL ar_fields: got %h want id=%h addr=100 len=0 size=5 burst=1", fld, TB_ID);
    end
    checks++; if (!stable) begin errors++; $display("FAIL ar_stable: got changing want stable"); end
    serve_r(0, d, 2'b00, wok, ok);
    checks++; if (!ok) begin errors++; $display("FAIL r_handshake: got timeout want handshake"); end
    wait_fall(n, ok);
    checks++; if (!ok || n != 1) begin errors++; $display("FAIL start_latency: got %0d want 1", n); end
    wait_done(2000, n, errAt, ok);
    checks++; if (!ok || n != 32*10*CPB) begin
      errors++; $display("FAIL frame_time: got %0d want %0d", n, 32*10*CPB);
    end
    checks++; if (errAt !== 1'b0) begin errors++; $display("FAIL done_err: got %b want 0", errAt); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL post_done: got busy=%b done=%b want 0 0", busy, done);
    end
    checks++; if (expQ.size() != 0) begin errors++; $display("FAIL bytes_left: got %0d want 0", expQ.size()); end
    @(posedge clk);
    checks++; if (doneCnt - d0 != 1) begin errors++; $display("FAIL done_count: got %0d want 1", doneCnt - d0); end
  endtask

  task automatic test_rwait_delay();
    int vcyc, n;
    logic [56:0] fld;
    logic errAt;
    bit stable, ok, wok;
    issue(32'h0000_2000);
    serve_ar(0, vcyc, fld, stable, ok);
    checks++; if (!ok || vcyc != 1) begin errors++; $display("FAIL ar_nodelay: got %0d want 1", vcyc); end
    checks++; if (fld[24:1] !== 24'h002000 >> 0 && fld[48:17] !== 32'h2000) begin
      errors++; $display("FAIL ar_addr2: got %h want 00002000", fld[48:17]);
    end
    serve_r(50, rand256(), 2'b00, wok, ok);
    checks++; if (!wok) begin errors++; $display("FAIL rwait_hold: got rready/tx dropped want rready=1 tx=1"); end
    wait_fall(n, ok);
    checks++; if (!ok || n != 1) begin errors++; $display("FAIL start_after_rvalid: got %0d want 1", n); end
    wait_done(2000, n, errAt, ok);
    checks++; if (!ok || n != 32*10*CPB) begin
      errors++; $display("FAIL frame_time2: got %0d want %0d", n, 32*10*CPB);
    end
    checks++; if (errAt !== 1'b0) begin errors++; $display("FAIL done_err2: got %b want 0", errAt); end
    @(negedge clk);
    checks++; if (expQ.size() != 0) begin errors++; $display("FAIL bytes_left2: got %0d want 0", expQ.size()); end
  endtask

  task automatic test_err_resp();
    int vcyc, lowSnap;
    logic [56:0] fld;
    bit stable, ok, wok;
    @(posedge clk); lowSnap = txLowCnt;
    issue(32'h0000_0400);
    serve_ar(1, vcyc, fld, stable, ok);
    serve_r(2, rand256(), 2'b10, wok, ok);
    @(negedge clk);
    checks++; if (done !== 1'b1 || err !== 1'b1) begin
      errors++; $display("FAIL err_done: got done=%b err=%b want 1 1", done, err);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL err_idle: got done=%b busy=%b want 0 0", done, busy);
    end
    repeat (10) @(negedge clk);
    @(posedge clk);
    checks++; if (txLowCnt != lowSnap) begin
      errors++; $display("FAIL err_tx_quiet: got %0d low cycles want 0", txLowCnt - lowSnap);
    end
    checks++; if (expQ.size() != 0) begin errors++; $display("FAIL err_bytes: got %0d want 0", expQ.size()); end
  endtask

  task automatic test_trig_ignored();
    int vcyc, n, d0, a0;
    logic [56:0] fld;
    logic errAt;
    bit stable, ok, wok;
    @(posedge clk); d0 = doneCnt; a0 = avCnt;
    issue(32'h0000_0800);
    serve_ar(0, vcyc, fld, stable, ok);
    serve_r(0, rand256(), 2'b00, wok, ok);
    wait_fall(n, ok);
    repeat (5*10*CPB + 6) @(negedge clk);
    @(posedge clk); #1;
    trig = 1'b1; addr = 32'hDEAD_0000;
    @(posedge clk); #1;
    trig = 1'b0;
    wait_done(2000, n, errAt, ok);
    checks++; if (!ok) begin errors++; $display("FAIL trig_done: got timeout want done"); end
    repeat (30) @(negedge clk);
    @(posedge clk);
    checks++; if (avCnt - a0 != 1) begin errors++; $display("FAIL trig_ar_count: got %0d want 1", avCnt - a0); end
    checks++; if (doneCnt - d0 != 1) begin errors++; $display("FAIL trig_done_count: got %0d want 1", doneCnt - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL trig_busy: got %b want 0", busy); end
    checks++; if (expQ.size() != 0) begin errors++; $display("FAIL trig_bytes: got %0d want 0", expQ.size()); end
  endtask

  task automatic test_reset_mid();
    int vcyc, n, d0;
    logic [56:0] fld;
    logic errAt;
    bit stable, ok, wok;
    @(posedge clk); d0 = doneCnt;
    issue(32'h0000_0C00);
    serve_ar(0, vcyc, fld, stable, ok);
    serve_r(0, 256'h0, 2'b00, wok, ok);
    wait_fall(n, ok);
    repeat (10*10*CPB + 8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL midrst_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (avalid !== 1'b0 || rready !== 1'b0) begin
      errors++; $display("FAIL midrst_axi: got avalid=%b rready=%b want 0 0", avalid, rready);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expQ.delete();
    repeat (20) @(negedge clk);
    @(posedge clk);
    checks++; if (doneCnt != d0) begin errors++; $display("FAIL midrst_done: got %0d pulses want 0", doneCnt - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: got %b want 0", busy); end
    issue(32'h0000_0040);
    serve_ar(2, vcyc, fld, stable, ok);
    checks++; if (!ok || fld[48:17] !== 32'h40) begin
      errors++; $display("FAIL rerun_addr: got %h want 00000040", fld[48:17]);
    end
    serve_r(0, rand256(), 2'b00, wok, ok);
    wait_done(2000, n, errAt, ok);
    checks++; if (!ok || errAt !== 1'b0) begin
      errors++; $display("FAIL rerun_done: got ok=%0d err=%b want 1 0", ok, errAt);
    end
    @(negedge clk);
    checks++; if (expQ.size() != 0) begin errors++; $display("FAIL rerun_bytes: got %0d want 0", expQ.size()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_readback();
    test_rwait_delay();
    test_err_resp();
    test_trig_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_uart_readback.md
DDR_UART_READBACK -- requirements
Module: ddr_uart_readback

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 87, meaning i_clk cycles per UART bit (legal range 4..65535).
REQ-002 The block SHALL have parameter AXI_ID, default 8'h01, meaning the fixed ID driven on the read address channel.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 i_clk  in  1  single clock for AXI and UART logic.
REQ-005 i_rst_n  in  1  asynchronous active-low reset.
REQ-006 i_trig  in  1  single-cycle readback request; sampled only in IDLE.
REQ-007 i_addr  in  32  DDR byte address, 32-byte aligned; latched on an accepted i_trig.
REQ-008 DdrCtrl_AID_0 / AADDR_0 / ALEN_0 / ASIZE_0 / ABURST_0 / ALOCK_0  out  8/32/8/3/2/2  read address fields.
REQ-009 DdrCtrl_AVALID_0  out  1; DdrCtrl_AREADY_0  in  1; DdrCtrl_ATYPE_0  out  1  (0 = read).
REQ-010 DdrCtrl_RDATA_0  in  256; DdrCtrl_RVALID_0  in  1; DdrCtrl_RLAST_0  in  1; DdrCtrl_RRESP_0  in  2; DdrCtrl_RREADY_0  out  1.
REQ-011 o_tx  out  1  UART 8N1 serial output, idle high.
REQ-012 o_busy  out  1  high in every state except IDLE.
REQ-013 o_done  out  1  one-cycle pulse at the end of a readback.
REQ-014 o_err  out  1  valid with o_done; high if RRESP was nonzero.

Function
REQ-015 The FSM SHALL have states IDLE, AREQ, RWAIT, TX_START, TX_DATA, TX_STOP and DONE.
REQ-016 IDLE: i_trig=1 SHALL latch i_addr, clear the byte index to 0 and enter AREQ on the next cycle.
REQ-017 AREQ: AVALID_0=1, ATYPE_0=0, ALEN_0=0, ASIZE_0=3'd5, ABURST_0=2'b01, ALOCK_0=0, AID_0=AXI_ID, AADDR_0=latched address; on AVALID&&AREADY, go to RWAIT.
REQ-018 AVALID_0 and the address fields SHALL stay stable until AREADY is sampled high.
REQ-019 RWAIT: RREADY_0=1; on RVALID&&RREADY, latch RDATA_0 into a 256-bit shift buffer and RRESP_0 into the error flag.
REQ-020 RWAIT exit: RRESP==0 goes to TX_START; RRESP!=0 goes to DONE with o_err=1 and no UART output.
REQ-021 RLAST_0 SHALL be ignored; RREADY_0 SHALL be 0 outside RWAIT.
REQ-022 TX_START: o_tx=0 for CLKS_PER_BIT cycles.
REQ-023 TX_DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles.
REQ-024 TX_STOP: o_tx=1 for CLKS_PER_BIT cycles.
REQ-025 Byte n SHALL be buffer[8n+7:8n], so byte 0 = RDATA[7:0] and byte 31 = RDATA[255:248].
REQ-026 After TX_STOP, the FSM SHALL go to TX_START if byte index < 31 (index+1), else to DONE.
REQ-027 Bytes SHALL be back-to-back with no idle bits between stop and the next start.
REQ-028 DONE lasts one cycle: o_done=1, o_err=latched flag, then return to IDLE.
REQ-029 Total frame time SHALL be exactly 32*10*CLKS_PER_BIT cycles from the first start-bit edge to the end of the last stop bit.
REQ-030 i_trig outside IDLE SHALL be ignored and not queued.
REQ-031 The bit counter SHALL wrap 0..CLKS_PER_BIT-1 with no drift across 320 bits.
REQ-032 DdrCtrl_WID_0 and the write channel are not driven by this block; it is read-only.

Reset
REQ-033 On i_rst_n=0, asynchronously: state=IDLE, o_tx=1, AVALID_0=0, RREADY_0=0, o_busy=0, o_done=0, o_err=0, all counters and the buffer = 0.
REQ-034 Reset mid-operation SHALL abort immediately: o_tx returns high, no o_done is produced, and no AXI handshake is completed afterward.
REQ-035 Outstanding AXI transactions across reset are the system's responsibility.

Verification
REQ-036 CLKS_PER_BIT=4, i_addr=32'h100, AREADY delayed 3 cycles -> AVALID held 4 cycles with AADDR=32'h100, ALEN=0, ASIZE=5.
REQ-037 RDATA=256'h1F1E...0100, RRESP=0 -> UART decodes bytes 00,01,...,1F in order; o_done after 1280 cycles of UART output; o_err=0.
REQ-038 RRESP=2'b10 -> o_tx stays 1 throughout, o_done=1 and o_err=1 one cycle after the R handshake.
REQ-039 i_trig pulsed during TX_DATA of byte 5 -> no second AR request; exactly one o_done.
REQ-040 i_rst_n asserted during byte 10 -> o_tx=1 the same cycle, o_busy=0, no o_done; a new i_trig then completes normally.
REQ-041 RVALID held low for 50 cycles in RWAIT -> RREADY stays 1, o_tx stays 1, and transmission starts after RVALID rises.
